pc_sequencer: RTL and testbench

Fetch/execute controller for the Hack CPU that owns the program counter's control pins: reset, load, inc and in.
- Requests each instruction from instruction ROM with a ready handshake and latches it.
- Decodes the C-instruction jump field against the ALU flags.
- Issues exactly one PC update per executed instruction.
- Sits between the ROM, the CPU datapath (A register, ALU flags) and the PC.

---
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the Hack PC control pins from ROM handshake and ALU flags.
// Optional HALT_DETECT_EN adds a sticky halted output for the "@L; 0;JMP" end loop.
module pc_sequencer #(
  parameter int WIDTH    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] instr,
  input  logic             rom_ready,
  input  logic [WIDTH-1:0] a_reg,
  input  logic             zr,
  input  logic             ng,
  input  logic [WIDTH-1:0] pc_cur,
  output logic             rom_req,
  output logic [WIDTH-1:0] instr_reg,
  output logic             exec_en,
  output logic             pc_reset,
  output logic             pc_load,
  output logic             pc_inc,
  output logic [WIDTH-1:0] pc_in,
  output logic             timeout,
`ifdef HALT_DETECT_EN
  output logic             halted,
`endif
  output logic [1:0]       state
);

  // state   | meaning
  // IDLE    | waiting for run, no strobes
  // FETCH   | rom_req high, waiting for rom_ready (bounded by MAX_WAIT)
  // EXECUTE | one-cycle commit, exactly one of pc_load/pc_inc
  // ERROR   | ROM timeout, held until reset

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    EXECUTE = 2'd2,
    ERROR   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wait_cnt, wait_d;
  logic [WIDTH-1:0] instr_d;
  logic             timeout_d;
  logic             jump;
  logic             halt_hit;
  logic             halted_q;
  logic             halted_d;

  wire              c_bit = instr_reg[WIDTH-1];
  wire [2:0]        j     = instr_reg[2:0];

  assign jump = c_bit & ((j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr));

`ifdef HALT_DETECT_EN
  assign halt_hit = (state_q == EXECUTE) & c_bit & (j == 3'b111) &
                    (a_reg == (pc_cur - WIDTH'(1)));
  assign halted   = halted_q;
`else
  logic unused_pc;
  assign unused_pc = ^pc_cur;
  assign halt_hit  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      instr_reg <= '0;
      wait_cnt  <= '0;
      timeout   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_reg <= instr_d;
      wait_cnt  <= wait_d;
      timeout   <= timeout_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_reg;
    wait_d    = wait_cnt;
    timeout_d = timeout;
    halted_d  = halted_q;
    case (state_q)
      IDLE: begin
        if (run && !halted_q) begin
          state_d = FETCH;
          wait_d  = '0;
        end
      end
      FETCH: begin
        if (rom_ready) begin
          instr_d = instr;
          state_d = EXECUTE;
        end else if (!run) begin
          state_d = IDLE;
        end else if (wait_cnt == CW'(MAX_WAIT)) begin
          state_d   = ERROR;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_cnt + CW'(1);
        end
      end
      EXECUTE: begin
        // A halt still takes the jump this cycle; only the next fetch is suppressed.
        if (halt_hit) begin
          halted_d = 1'b1;
          state_d  = IDLE;
        end else if (run) begin
          state_d = FETCH;
          wait_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = ERROR;
    endcase
  end

  always_comb begin
    rom_req  = 1'b0;
    exec_en  = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_reset = reset;
    pc_in    = a_reg;
    if (!reset) begin
      case (state_q)
        FETCH:   rom_req = 1'b1;
        EXECUTE: begin
          exec_en = 1'b1;
          pc_load = jump;
          pc_inc  = ~jump;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: ROM driver pushes expected executions, a monitor checks them.
module tb_pc_sequencer;
  localparam int W  = 16;
  localparam int MW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, run, rom_ready, zr, ng;
  logic [W-1:0] instr, a_reg, pc;
  logic         rom_req, exec_en, pc_reset, pc_load, pc_inc, timeout;
  logic [W-1:0] instr_reg, pc_in;
  logic [1:0]   state;
`ifdef HALT_DETECT_EN
  logic         halted;
`endif

  pc_sequencer #(.WIDTH(W), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .rom_ready(rom_ready),
    .a_reg(a_reg), .zr(zr), .ng(ng), .pc_cur(pc), .rom_req(rom_req),
    .instr_reg(instr_reg), .exec_en(exec_en), .pc_reset(pc_reset),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_in(pc_in), .timeout(timeout),
`ifdef HALT_DETECT_EN
    .halted(halted),
`endif
    .state(state)
  );

  // Program counter driven by the sequencer strobes.
  always @(posedge clk) begin
    if (pc_reset)     pc <= '0;
    else if (pc_load) pc <= pc_in;
    else if (pc_inc)  pc <= pc + 16'd1;
  end

  typedef struct {
    logic [W-1:0] ins;
    bit           ld;
    bit           inc;
    logic [W-1:0] a;
    logic [W-1:0] pc_b;
    logic [W-1:0] pc_a;
    int           fc;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] ref_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Jump rule from the ALU result sign: LT/EQ/GT bits select the taken cases.
  function automatic bit ref_jump(input logic [W-1:0] ins, input int r);
    if (!ins[15]) return 1'b0;
    return (r < 0 && ins[2]) || (r == 0 && ins[1]) || (r > 0 && ins[0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!rom_req && n < 50) begin
      step();
      n++;
    end
    if (!rom_req) chk("rom_req_wait", {31'd0, rom_req}, 32'd1);
  endtask

  task automatic issue(input logic [W-1:0] ins, input logic [W-1:0] a, input int r, input int waits);
    exp_t e;
    wait_req();
    repeat (waits) begin
      rom_ready = 1'b0;
      instr     = W'($urandom);
      step();
    end
    instr     = ins;
    a_reg     = a;
    zr        = (r == 0);
    ng        = (r < 0);
    rom_ready = 1'b1;
    e.ins  = ins;
    e.ld   = ref_jump(ins, r);
    e.inc  = !e.ld;
    e.a    = a;
    e.pc_b = ref_pc;
    e.pc_a = e.ld ? a : ref_pc + 16'd1;
    e.fc   = waits + 1;
    ref_pc = e.pc_a;
    sbq.push_back(e);
    step();
    rom_ready = 1'b0;
  endtask

  // Monitor
  int           fcnt = 0;
  bit           pend = 1'b0;
  logic [W-1:0] pend_pc;
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      chk("pc_after_exec", {16'd0, pc}, {16'd0, pend_pc});
      pend = 1'b0;
    end
    if (exec_en) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_exec: exec_en=1 with no pending fetch at %0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("instr_reg", {16'd0, instr_reg}, {16'd0, e.ins});
        chk("pc_load",   {31'd0, pc_load}, {31'd0, e.ld});
        chk("pc_inc",    {31'd0, pc_inc},  {31'd0, e.inc});
        if (e.ld) chk("pc_in", {16'd0, pc_in}, {16'd0, e.a});
        chk("pc_before_exec", {16'd0, pc}, {16'd0, e.pc_b});
        chk("fetch_cycles", fcnt, e.fc);
        pend    = 1'b1;
        pend_pc = e.pc_a;
      end
      fcnt = 0;
    end else begin
      chk("no_pc_strobe", {30'd0, pc_load, pc_inc}, 32'd0);
      if (rom_req) fcnt++;
      else fcnt = 0;
    end
  end

  initial begin
    int n;
    logic [W-1:0] a, ins;
    reset = 1'b1; run = 1'b0; rom_ready = 1'b0; instr = '0; a_reg = '0; zr = 1'b0; ng = 1'b0;
    ref_pc = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pc_reset", {31'd0, pc_reset}, 32'd1);
    chk("rst_strobes", {28'd0, rom_req, exec_en, pc_load, pc_inc}, 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_instr_reg", {16'd0, instr_reg}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_pc", {16'd0, pc}, 32'd0);
    step();
    run = 1'b1;

    issue(16'h0005, 16'h1234, 1, 0);
    issue(16'hE302, 16'd100, 0, 0);
    issue(16'hE302, 16'd55, -3, 0);
    issue(16'hE301, 16'd200, 5, 0);
    issue(16'hE304, 16'd300, -1, 0);
    issue(16'h0007, 16'd9, 0, 3);

    for (int i = 0; i < 150; i++) begin
      ins = W'($urandom);
      a   = W'($urandom);
      if (a == ref_pc - 16'd1) a = a + 16'd2;
      issue(ins, a, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 4)));
    end

    // Abort during a wait.
    wait_req();
    rom_ready = 1'b0;
    step();
    step();
    run = 1'b0;
    step();
    chk("abort_state", {30'd0, state}, 32'd0);
    @(negedge clk);
    chk("abort_exec", {31'd0, exec_en}, 32'd0);
    chk("abort_pc", {16'd0, pc}, {16'd0, ref_pc});

    // ROM timeout.
    step();
    run = 1'b1;
    wait_req();
    n = 0;
    while (state != 2'd3 && n < 40) begin
      if (rom_req) n++;
      step();
    end
    chk("timeout_cycles", n, MW + 1);
    chk("err_state", {30'd0, state}, 32'd3);
    chk("err_timeout", {31'd0, timeout}, 32'd1);
    chk("err_rom_req", {31'd0, rom_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      step();
      chk("err_sticky", {30'd0, state}, 32'd3);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    ref_pc = '0;
    chk("err_clr_state", {30'd0, state}, 32'd0);
    chk("err_clr_timeout", {31'd0, timeout}, 32'd0);
    chk("err_clr_pc", {16'd0, pc}, 32'd0);

    // Reset during a taken-jump EXECUTE.
    run = 1'b1;
    issue(16'h0001, 16'd7, 1, 0);
    wait_req();
    instr = 16'hE387; a_reg = 16'd100; zr = 1'b0; ng = 1'b0; rom_ready = 1'b1;
    step();
    rom_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rexec_pc_load", {31'd0, pc_load}, 32'd0);
    chk("rexec_pc_reset", {31'd0, pc_reset}, 32'd1);
    chk("rexec_exec_en", {31'd0, exec_en}, 32'd0);
    step();
    reset = 1'b0;
    ref_pc = '0;
    chk("rexec_pc", {16'd0, pc}, 32'd0);
    chk("rexec_state", {30'd0, state}, 32'd0);
    chk("rexec_instr_reg", {16'd0, instr_reg}, 32'd0);

`ifdef HALT_DETECT_EN
    for (int i = 0; i < 5; i++) issue(W'(i + 1), 16'd0, 1, 0);
    issue(16'hEA87, 16'd4, 1, 0);
    step();
    step();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_state", {30'd0, state}, 32'd0);
    chk("halt_pc", {16'd0, pc}, 32'd4);
    chk("halt_no_req", {31'd0, rom_req}, 32'd0);
`else
    issue(16'hEA87, 16'd0, 1, 0);
`endif

    run = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
